// File: rtl/Pipe_Buf_Reg_PKG.sv
// Pipeline buffer register types shared across stages, plus the retire-trace
// record produced at the write-back end.
package Pipe_Buf_Reg_PKG;

    typedef struct packed {
        logic [31:0] Pc_Four;
        logic [31:0] Curr_Instr;
        logic [31:0] Alu_Result;
        logic [31:0] MemReadData;
        logic [31:0] Imm_Out;
        logic [31:0] Pc_Imm;
        logic [4:0]  rd;
        logic        RegWrite;
        logic        MemtoReg;
    } mem_wb_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        we;
    } trace_rec_t;

    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with extended-MSB read/write counters; head output reads
// as zero while empty.
module trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_cnt_q, wr_cnt_d;
    logic [AW:0]  rd_cnt_q, rd_cnt_d;
    logic         do_push, do_pop;

    assign level = wr_cnt_q - rd_cnt_q;
    assign empty = (wr_cnt_q == rd_cnt_q);
    assign full  = (level == (AW+1)'(DEPTH));
    assign dout  = empty ? '0 : mem_q[rd_cnt_q[AW-1:0]];

    // A pop frees the head slot in the same edge, so a full FIFO still accepts a push.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (do_push) wr_cnt_d = wr_cnt_q + (AW+1)'(1);
        if (do_pop)  rd_cnt_d = rd_cnt_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_cnt_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_retire_tracer.sv
// Write-back retirement tracer: builds a trace record for each retiring
// instruction, queues it for the debug side, and keeps retire/drop statistics.
module wb_retire_tracer
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trace_en,
    input  mem_wb_reg               wb_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output trace_rec_t              out_rec,
    output logic                    overflow,
    input  logic                    clr_stat,
    output logic [CNT_W-1:0]        retired_cnt,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic [$clog2(DEPTH):0]  level
);

    trace_rec_t        rec;
    logic              retire;
    logic              drop;
    logic              fifo_full, fifo_empty;
    logic [$bits(trace_rec_t)-1:0] fifo_dout;
    logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;

    assign retire = trace_en && (wb_in.Curr_Instr != '0);

    always_comb begin
        rec       = '0;
        rec.pc    = wb_in.Pc_Four - 32'd4;
        rec.instr = wb_in.Curr_Instr;
        rec.rd    = wb_in.rd;
        rec.we    = wb_in.RegWrite && (wb_in.rd != 5'd0);
        if (rec.we) begin
            case (wb_in.Curr_Instr[6:0])
                OPC_JAL, OPC_JALR: rec.wdata = wb_in.Pc_Four;
                OPC_LUI:           rec.wdata = wb_in.Imm_Out;
                OPC_AUIPC:         rec.wdata = wb_in.Pc_Imm;
                default:           rec.wdata = wb_in.MemtoReg ? wb_in.MemReadData : wb_in.Alu_Result;
            endcase
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(trace_rec_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (retire),
        .din   (rec),
        .pop   (out_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_valid = !fifo_empty;
    assign out_rec   = fifo_dout;
    // Full implies non-empty, so out_ready alone tells whether the head pops this edge.
    assign drop      = retire && fifo_full && !out_ready;

    always_comb begin
        retired_cnt_d = retired_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        overflow_d    = overflow_q;
        if (clr_stat) begin
            retired_cnt_d = '0;
            drop_cnt_d    = '0;
            overflow_d    = 1'b0;
        end else begin
            if (retire) retired_cnt_d = retired_cnt_q + CNT_W'(1);
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt_q <= '0;
            drop_cnt_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_wb_retire_tracer.sv
// Bench for wb_retire_tracer: directed vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_wb_retire_tracer;
    import Pipe_Buf_Reg_PKG::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    mem_wb_reg   wb_in;
    logic        out_valid;
    logic        out_ready;
    trace_rec_t  out_rec;
    logic        overflow;
    logic        clr_stat;
    logic [31:0] retired_cnt;
    logic [15:0] drop_cnt;
    logic [3:0]  level;

    int n_total = 0;
    int n_pass  = 0;

    trace_rec_t  mq[$];
    logic [31:0] m_ret;
    logic [15:0] m_drop;
    logic        m_ovf;

    wb_retire_tracer #(
        .DEPTH  (DEPTH),
        .CNT_W  (32),
        .DROP_W (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trace_en    (trace_en),
        .wb_in       (wb_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rec     (out_rec),
        .overflow    (overflow),
        .clr_stat    (clr_stat),
        .retired_cnt (retired_cnt),
        .drop_cnt    (drop_cnt),
        .level       (level)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endfunction

    function automatic void chk_rec(string nm, trace_rec_t act, trace_rec_t exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endfunction

    function automatic mem_wb_reg mk(logic [31:0] instr, logic [31:0] pcf, logic rw, logic m2r,
                                     logic [31:0] alu, logic [31:0] mrd, logic [31:0] imm,
                                     logic [31:0] pcimm, logic [4:0] rd);
        mem_wb_reg w;
        w.Curr_Instr  = instr;
        w.Pc_Four     = pcf;
        w.RegWrite    = rw;
        w.MemtoReg    = m2r;
        w.Alu_Result  = alu;
        w.MemReadData = mrd;
        w.Imm_Out     = imm;
        w.Pc_Imm      = pcimm;
        w.rd          = rd;
        return w;
    endfunction

    // Expected record straight from the retire rules
    function automatic trace_rec_t ref_rec(mem_wb_reg w);
        trace_rec_t r;
        logic [6:0] opc;
        opc     = w.Curr_Instr[6:0];
        r.pc    = w.Pc_Four - 32'd4;
        r.instr = w.Curr_Instr;
        r.rd    = w.rd;
        r.we    = w.RegWrite && (w.rd != 5'd0);
        if (!r.we)                                r.wdata = 32'h0;
        else if (opc == OPC_JAL || opc == OPC_JALR) r.wdata = w.Pc_Four;
        else if (opc == OPC_LUI)                  r.wdata = w.Imm_Out;
        else if (opc == OPC_AUIPC)                r.wdata = w.Pc_Imm;
        else if (w.MemtoReg)                      r.wdata = w.MemReadData;
        else                                      r.wdata = w.Alu_Result;
        return r;
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_ret  = '0;
        m_drop = '0;
        m_ovf  = 1'b0;
    endfunction

    function automatic void model_step();
        bit ret, popped, dropped;
        int was;
        if (reset) begin
            model_clear();
            return;
        end
        ret     = trace_en && (wb_in.Curr_Instr != 32'h0);
        was     = mq.size();
        popped  = (was > 0) && out_ready;
        dropped = 0;
        if (popped) void'(mq.pop_front());
        if (ret) begin
            if (was < DEPTH || popped) mq.push_back(ref_rec(wb_in));
            else dropped = 1;
        end
        if (clr_stat) begin
            m_ret  = '0;
            m_drop = '0;
            m_ovf  = 1'b0;
        end else begin
            if (ret) m_ret = m_ret + 1;
            if (dropped) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
            end
        end
    endfunction

    function automatic void compare_all();
        trace_rec_t e;
        e = (mq.size() > 0) ? mq[0] : '0;
        chk("m_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("m_level", 32'(level), 32'(mq.size()));
        chk_rec("m_rec", out_rec, e);
        chk("m_ovf", 32'(overflow), 32'(m_ovf));
        chk("m_retired", retired_cnt, m_ret);
        chk("m_drop", 32'(drop_cnt), 32'(m_drop));
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    typedef struct {
        mem_wb_reg   wb;
        logic [31:0] e_pc;
        logic [31:0] e_wdata;
        logic        e_we;
    } vec_t;

    vec_t        vecs[8];
    mem_wb_reg   bubble;
    int          drain_exp[8] = '{1, 2, 3, 4, 5, 6, 7, 10};

    initial begin
        bubble = mk(32'h0, 32'h50, 1'b1, 1'b0, 32'h33, 32'h44, 32'h55, 32'h66, 5'd9);
        vecs[0] = '{mk(32'h00500293, 32'h10,   1, 0, 32'h5,    32'h0,    32'h0,        32'h0,    5), 32'h0C,       32'h5,        1'b1};
        vecs[1] = '{mk(32'h008000EF, 32'h24,   1, 0, 32'hDEAD, 32'h0,    32'h0,        32'h0,    1), 32'h20,       32'h24,       1'b1};
        vecs[2] = '{mk(32'h0000A383, 32'h28,   1, 1, 32'h100,  32'h1234, 32'h0,        32'h0,    7), 32'h24,       32'h1234,     1'b1};
        vecs[3] = '{mk(32'h0070A023, 32'h2C,   0, 0, 32'h55,   32'h0,    32'h0,        32'h0,    0), 32'h28,       32'h0,        1'b0};
        vecs[4] = '{mk(32'h123451B7, 32'h30,   1, 0, 32'h77,   32'h0,    32'h12345000, 32'h0,    3), 32'h2C,       32'h12345000, 1'b1};
        vecs[5] = '{mk(32'h00001217, 32'h1004, 1, 0, 32'h77,   32'h0,    32'h0,        32'h2000, 4), 32'h1000,     32'h2000,     1'b1};
        vecs[6] = '{mk(32'h00100013, 32'h40,   1, 0, 32'h1,    32'h0,    32'h0,        32'h0,    0), 32'h3C,       32'h0,        1'b0};
        vecs[7] = '{mk(32'h000080E7, 32'h0,    1, 0, 32'h9,    32'h0,    32'h0,        32'h0,    1), 32'hFFFFFFFC, 32'h0,        1'b1};

        reset = 1'b1; trace_en = 1'b0; out_ready = 1'b0; clr_stat = 1'b0; wb_in = bubble;
        model_clear();
        tick();
        tick();
        reset = 1'b0;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk_rec("reset_rec", out_rec, '0);
        tick();

        // Directed vector table, one record at a time through an empty FIFO
        trace_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wb_in = vecs[i].wb; out_ready = 1'b0;
            tick();
            wb_in = bubble;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_pc", i), out_rec.pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_wdata", i), out_rec.wdata, vecs[i].e_wdata);
            chk($sformatf("vec%0d_we", i), 32'(out_rec.we), 32'(vecs[i].e_we));
            chk($sformatf("vec%0d_rd", i), 32'(out_rec.rd), 32'(vecs[i].wb.rd));
            tick();
            chk($sformatf("vec%0d_stall_hold", i), out_rec.pc, vecs[i].e_pc);
            out_ready = 1'b1;
            tick();
        end
        chk("retired_after_vecs", retired_cnt, 32'd8);
        wb_in = bubble;
        tick();
        chk("bubble_no_rec", 32'(out_valid), 32'd0);

        // Overflow: 10 retires into an 8-deep FIFO with no consumer
        clr_stat = 1'b1; tick(); clr_stat = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wb_in = mk(32'h00500293, 32'h1000 + 32'(4 * (i + 1)), 1, 0, 32'(i), 0, 0, 0, 5);
            tick();
        end
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_retired", retired_cnt, 32'd10);

        // Full, retire and pop together: no drop
        wb_in = mk(32'h00500293, 32'h1000 + 32'(4 * 11), 1, 0, 32'd10, 0, 0, 0, 5);
        out_ready = 1'b1;
        tick();
        chk("fullpop_level", 32'(level), 32'd8);
        chk("fullpop_drop", 32'(drop_cnt), 32'd2);

        // Clear coinciding with a drop
        wb_in = mk(32'h00500293, 32'h1000 + 32'(4 * 12), 1, 0, 32'd11, 0, 0, 0, 5);
        out_ready = 1'b0; clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        chk("clr_retired", retired_cnt, 32'd0);
        chk("clr_level_kept", 32'(level), 32'd8);

        wb_in = bubble; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d_pc", k), out_rec.pc, 32'h1000 + 32'(4 * drain_exp[k]));
            tick();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Capture disabled
        trace_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_in = mk(32'h00500293, 32'h2000 + 32'(4 * i), 1, 0, 32'(i), 0, 0, 0, 5);
            tick();
        end
        chk("dis_no_rec", 32'(out_valid), 32'd0);
        chk("dis_retired", retired_cnt, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            logic [31:0] r, r2, r3;
            logic [6:0]  opc;
            r = $urandom; r2 = $urandom; r3 = $urandom;
            case (r[2:0])
                3'd0: opc = OPC_JAL;
                3'd1: opc = OPC_JALR;
                3'd2: opc = OPC_LUI;
                3'd3: opc = OPC_AUIPC;
                3'd4: opc = 7'b0000011;
                3'd5: opc = 7'b0010011;
                3'd6: opc = 7'b0110011;
                default: opc = 7'b0100011;
            endcase
            wb_in = mk((r[5:3] == 3'd0) ? 32'h0 : {r2[31:7], opc}, r3, r[6], r[7],
                       $urandom, $urandom, $urandom, $urandom,
                       (r[10:8] == 3'd0) ? 5'd0 : r2[4:0]);
            out_ready = (r[13:11] < 3'd5);
            trace_en  = (r[17:14] != 4'd0);
            clr_stat  = (r[23:18] == 6'd0);
            tick();
        end

        // Asynchronous reset with entries queued
        trace_en = 1'b1; clr_stat = 1'b0; out_ready = 1'b1; wb_in = bubble;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_in = mk(32'h00500293, 32'h3000 + 32'(4 * i), 1, 0, 32'(i), 0, 0, 0, 5);
            tick();
        end
        chk("pre_reset_level", 32'(level), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_level", 32'(level), 32'd0);
        chk("async_retired", retired_cnt, 32'd0);
        chk("async_drop", 32'(drop_cnt), 32'd0);
        chk("async_ovf", 32'(overflow), 32'd0);
        tick();
        reset = 1'b0; wb_in = bubble;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_retire_tracer.md
Name: wb_retire_tracer

Overview:
Retirement tracer at the write-back end of the five-stage pipeline; consumes the MEM/WB pipeline register each cycle. Every real instruction leaving WB becomes a trace record {pc, instr, rd, wdata, we}, buffered in a FIFO and drained over a valid/ready port to the debug/testbench side. Also keeps a retired-instruction counter and a dropped-record counter with a sticky overflow flag.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
CNT_W, 32, width of retired counter
DROP_W, 16, width of dropped counter (saturating)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
trace_en  in  1  capture enable; 0 = no capture, counters frozen
wb_in  in  mem_wb_reg  MEM/WB register contents (Pipe_Buf_Reg_PKG)
out_valid  out  1  head record available
out_ready  in  1  consumer accepts head record
out_rec  out  trace_rec_t  head record; all-zero when empty
overflow  out  1  sticky: a record was dropped since reset/clear
clr_stat  in  1  synchronous clear of overflow, retired_cnt, drop_cnt
retired_cnt  out  CNT_W  instructions retired while trace_en=1
drop_cnt  out  DROP_W  records lost to full FIFO
level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, active-high): FIFO empty, pointers 0, out_valid=0, out_rec=0, overflow=0, retired_cnt=0, drop_cnt=0, level=0.
- Retire condition (combinational, cycle t): trace_en=1 and wb_in.Curr_Instr != 32'h0 (flushed/bubble stages are all-zero).
- Record build: pc = wb_in.Pc_Four - 4 (32-bit, wraps mod 2^32); instr = Curr_Instr; rd = wb_in.rd; we = RegWrite and rd != 0.
- wdata by opcode Curr_Instr[6:0]: 1101111/1100111 (JAL/JALR) -> Pc_Four; 0110111 (LUI) -> Imm_Out; 0010111 (AUIPC) -> Pc_Imm; else MemtoReg ? MemReadData : Alu_Result. wdata forced to 0 when we=0.
- Push on retire at edge t; out_valid/out_rec reflect it from cycle t+1 if FIFO was empty (1-cycle latency). No combinational path from wb_in to outputs.
- Pop: out_valid & out_ready at an edge advances head; out_rec must hold stable while out_valid=1 and out_ready=0.
- Full and retire, no pop: record dropped, drop_cnt +1 (saturates at all-ones), overflow <= 1; retired_cnt still increments.
- Full and retire with simultaneous pop: both succeed, level unchanged, no drop.
- Empty and pop attempt: ignored (out_valid=0).
- retired_cnt +1 per retire, wraps at 2^CNT_W.
- clr_stat=1: overflow, retired_cnt, drop_cnt cleared that edge; takes priority over same-cycle increments. FIFO contents untouched.
- trace_en=0: no push, counters hold; draining continues.
- Pointers wrap mod DEPTH; level = wr_cnt - rd_cnt with extra MSB to distinguish full/empty.

Decomposition:
- Add trace_rec_t (pc[31:0], instr[31:0], rd[4:0], wdata[31:0], we) and opcode constants OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC to Pipe_Buf_Reg_PKG alongside mem_wb_reg.
- One sub-module: trace_fifo (parameterised sync FIFO: push/pop, full/empty, level, async reset); record build and counters stay in the top.

Test Plan:
- Reset mid-stream with 3 entries queued -> out_valid=0, level=0, counters 0 on the very next sample, even without a clock edge.
- ADDI x5 (instr 0x00500293, Pc_Four=0x10, RegWrite=1, Alu_Result=5) -> next cycle out_rec={pc=0x0C, rd=5, wdata=5, we=1}, retired_cnt=1.
- JAL x1 (Pc_Four=0x24, Alu_Result=0xDEAD) then LW x7 (MemtoReg=1, MemReadData=0x1234) -> wdata 0x24 then 0x1234; SW (RegWrite=0) -> we=0, wdata=0; bubble Curr_Instr=0 -> no record.
- DEPTH=8, out_ready=0, 10 retires -> level=8, drop_cnt=2, overflow=1, retired_cnt=10; then drain -> 8 records in order, oldest first.
- Full FIFO, retire and out_ready=1 same cycle -> level stays 8, drop_cnt unchanged; clr_stat pulse coinciding with a drop -> overflow=0, drop_cnt=0 after the edge.
- rd=0 with RegWrite=1 -> we=0, wdata=0; trace_en=0 for 4 retires -> no records, retired_cnt unchanged.
